// File: rtl/ahb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_mem_slave
//  Description : AHB-Lite responder backed by a word-organised memory bank.
//                Supports byte, halfword and word transfers (little-endian
//                lanes). OKAY data phases can be stretched by a programmable
//                number of wait states. Out-of-range, misaligned and
//                unsupported-size accesses get a two-cycle ERROR response.
//
//  Parameters  : MEM_DEPTH    number of 32-bit words (1..16384), word index
//                             is HADDR[15:2]
//                WAIT_STATES  HREADYout-low cycles per OKAY data phase (0..7)
//
//  Ports       : HCLK       in   1   bus clock
//                HRESETn    in   1   asynchronous active-low reset
//                HSEL       in   1   slave select from the address decoder
//                HADDR      in   32  byte address (bits 15:0 decoded)
//                HTRANS     in   2   IDLE/BUSY/NONSEQ/SEQ
//                HWRITE     in   1   1 = write
//                HSIZE      in   3   0 byte, 1 halfword, 2 word
//                HWDATA     in   32  write data (data phase)
//                HREADY     in   1   bus-level ready from the response mux
//                HRDATA     out  32  read data
//                HRESP      out  2   00 OKAY, 01 ERROR
//                HREADYout  out  1   this slave's ready
//
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_mem_slave #(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADYout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_idx_w      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [14:0] c_depth      = 15'(MEM_DEPTH);
    localparam logic [1:0]  c_resp_okay  = 2'b00;
    localparam logic [1:0]  c_resp_error = 2'b01;
    // The counter is loaded with WAIT_STATES-1 so that the ST_WAIT cycle that
    // sees zero is the last stalled cycle.
    localparam logic [2:0]  c_wait_load  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_hready;
    logic [1:0]           r_hresp;
    logic [2:0]           r_wait_cnt;

    // Latched address-phase information for the current data phase
    logic                 r_active;   // a legal transfer owns the data phase
    logic                 r_write;
    logic [1:0]           r_size;
    logic [1:0]           r_lane;     // byte offset within the word
    logic [c_idx_w-1:0]   r_idx;      // word index

    logic [31:0]          r_mem [MEM_DEPTH];

    logic                 w_accept;
    logic                 w_err;
    logic                 w_complete;
    logic [3:0]           w_be;
    logic                 w_unused;

    // ------------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------------
    // A new transfer can only be taken while this slave is not stalling the
    // bus (ST_IDLE, or the second ERROR cycle). In a well-formed system HREADY
    // is already low in the other states; the state term keeps a glitchy
    // HREADY from corrupting an in-flight response.
    assign w_accept = HSEL && HREADY && HTRANS[1] &&
                      ((r_state == ST_IDLE) || (r_state == ST_ERR2));

    always_comb begin
        w_err = 1'b0;
        if (HSIZE > 3'd2) begin
            w_err = 1'b1;
        end else if ((HSIZE == 3'd1) && HADDR[0]) begin
            w_err = 1'b1;
        end else if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end
        if ({1'b0, HADDR[15:2]} >= c_depth) begin
            w_err = 1'b1;
        end
    end

    // The data phase of a legal transfer finishes in the ST_IDLE cycle that
    // follows its accept (zero waits) or its last wait cycle.
    assign w_complete = (r_state == ST_IDLE) && r_active;

    // ------------------------------------------------------------------------
    // Byte-lane enables for the latched transfer (little-endian)
    // ------------------------------------------------------------------------
    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_lane;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered HREADYout / HRESP
    // ------------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_hready   <= 1'b1;
            r_hresp    <= c_resp_okay;
            r_wait_cnt <= 3'd0;
            r_active   <= 1'b0;
            r_write    <= 1'b0;
            r_size     <= 2'd0;
            r_lane     <= 2'd0;
            r_idx      <= '0;
        end else begin
            if (w_complete) begin
                r_active <= 1'b0;
            end

            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    if (w_accept) begin
                        r_write <= HWRITE;
                        r_size  <= HSIZE[1:0];
                        r_lane  <= HADDR[1:0];
                        r_idx   <= HADDR[c_idx_w+1:2];
                        if (w_err) begin
                            // Errors never stall beyond the mandatory first cycle
                            r_state  <= ST_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= c_resp_error;
                            r_active <= 1'b0;
                        end else if (WAIT_STATES > 0) begin
                            r_state    <= ST_WAIT;
                            r_hready   <= 1'b0;
                            r_hresp    <= c_resp_okay;
                            r_wait_cnt <= c_wait_load;
                            r_active   <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_hready <= 1'b1;
                            r_hresp  <= c_resp_okay;
                            r_active <= 1'b1;
                        end
                    end else begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= c_resp_okay;
                    end
                end

                ST_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= c_resp_okay;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end

                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= c_resp_error;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= c_resp_okay;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Memory array: writes commit at the edge that ends the completing cycle,
    // so a read accepted in that same cycle sees the new data next cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_complete && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Reads return the whole word regardless of size; the master picks lanes.
    assign HRDATA    = (r_active && !r_write) ? r_mem[r_idx] : 32'h0000_0000;
    assign HRESP     = r_hresp;
    assign HREADYout = r_hready;

    // Address bits above the decoded range and HTRANS[0] carry no meaning here
    assign w_unused = &{1'b0, HADDR, HTRANS};

endmodule
`default_nettype wire

// File: tb/tb_ahb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_mem_slave
//  Description : Three ahb_mem_slave instances (WAIT_STATES 0, 2, 3) on one
//                AHB-Lite bus with a response mux. A driver issues directed
//                transfers and queues the expected response; a monitor pops
//                and compares each completed data phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_mem_slave;

    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_NSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ  = 2'b11;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] ERR     = 2'b01;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        sel;
    logic [2:0]        hsel;
    logic [31:0]       haddr;
    logic [31:0]       hwdata;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic              force_nrdy;

    logic [2:0][31:0]  rdata;
    logic [2:0][1:0]   resp;
    logic [2:0]        rdy;

    logic [1:0]        dsel;
    logic              mux_rdy;
    logic [1:0]        mux_resp;
    logic [31:0]       mux_rdata;
    logic              hready_bus;

    always #5 clk = ~clk;

    assign hsel[0] = (sel == 2'd0);
    assign hsel[1] = (sel == 2'd1);
    assign hsel[2] = (sel == 2'd2);

    ahb_mem_slave #(.MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
        .HRDATA(rdata[0]), .HRESP(resp[0]), .HREADYout(rdy[0]));

    ahb_mem_slave #(.MEM_DEPTH(64), .WAIT_STATES(2)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
        .HRDATA(rdata[1]), .HRESP(resp[1]), .HREADYout(rdy[1]));

    ahb_mem_slave #(.MEM_DEPTH(64), .WAIT_STATES(3)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
        .HRDATA(rdata[2]), .HRESP(resp[2]), .HREADYout(rdy[2]));

    // Response mux; select 3 is an always-ready empty slot
    always_comb begin
        mux_rdy   = 1'b1;
        mux_resp  = OKAY;
        mux_rdata = 32'h0;
        case (dsel)
            2'd0: begin mux_rdy = rdy[0]; mux_resp = resp[0]; mux_rdata = rdata[0]; end
            2'd1: begin mux_rdy = rdy[1]; mux_resp = resp[1]; mux_rdata = rdata[1]; end
            2'd2: begin mux_rdy = rdy[2]; mux_resp = resp[2]; mux_rdata = rdata[2]; end
            default: ;
        endcase
    end

    assign hready_bus = mux_rdy & ~force_nrdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          dsel <= 2'd0;
        else if (hready_bus) dsel <= sel;
    end

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        int          waits;
        logic [1:0]  resp;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   wait_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every negedge while a data phase is outstanding
    always @(negedge clk) begin
        if (rst_n && (q.size() > 0)) begin
            if (!mux_rdy) begin
                wait_seen++;
                check({q[0].name, "_wresp"}, 32'(mux_resp), 32'(q[0].resp));
                if (wait_seen > 40) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL %s_timeout: %0d stalled cycles, expected %0d", q[0].name, wait_seen, q[0].waits);
                    void'(q.pop_front());
                    wait_seen = 0;
                end
            end else begin
                mon_e = q.pop_front();
                check({mon_e.name, "_waits"}, 32'(wait_seen), 32'(mon_e.waits));
                check({mon_e.name, "_resp"},  32'(mux_resp),  32'(mon_e.resp));
                check({mon_e.name, "_rdata"}, mux_rdata,      mon_e.rdata);
                wait_seen = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    task automatic xfer(input int s, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ew, input logic [1:0] er, input logic [31:0] erd, input string nm);
        int n;
        n      = 0;
        sel    = 2'(s);
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
        @(negedge clk);
        while (!hready_bus && (n < 50)) begin
            n++;
            @(negedge clk);
        end
        if (!hready_bus) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_accept: bus ready 0 after %0d cycles, expected 1", nm, n);
        end
        @(posedge clk);
        #1;
        htrans = TR_IDLE;
        hwdata = wd;
        q.push_back('{waits: ew, resp: er, rdata: erd, name: nm});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        sel        = 2'd0;
        haddr      = 32'h0;
        hwdata     = 32'h0;
        htrans     = TR_IDLE;
        hwrite     = 1'b0;
        hsize      = 3'd0;
        force_nrdy = 1'b0;

        // Reset state of every instance
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d_ready", k), 32'(rdy[k]),  32'h1);
            check($sformatf("rst%0d_resp", k),  32'(resp[k]), 32'h0);
            check($sformatf("rst%0d_rdata", k), rdata[k],     32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait word write/read, then byte and halfword lanes
        xfer(0, TR_NSEQ, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, OKAY, 32'h0,        "t1_wr");
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0,        0, OKAY, 32'hDEADBEEF, "t1_rd");
        xfer(0, TR_NSEQ, 1'b1, 3'd0, 32'h11, 32'h0000AB00, 0, OKAY, 32'h0,        "t2_wrb");
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0,        0, OKAY, 32'hDEADABEF, "t2_rd");
        xfer(0, TR_NSEQ, 1'b1, 3'd1, 32'h12, 32'h12340000, 0, OKAY, 32'h0,        "t2_wrh");
        xfer(0, TR_SEQ,  1'b0, 3'd0, 32'h13, 32'h0,        0, OKAY, 32'h1234ABEF, "t2_rdb");

        // Wait states on the WAIT_STATES=2 instance, then back to instance 0
        xfer(1, TR_NSEQ, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D, 2, OKAY, 32'h0,        "t3_wr");
        xfer(1, TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0,        2, OKAY, 32'hCAFEF00D, "t3_rd");
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0,        0, OKAY, 32'h1234ABEF, "t3_iso");

        // Error responses: out of range, misaligned, bad size; no wait states
        xfer(0, TR_NSEQ, 1'b1, 3'd2, 32'h100, 32'hFFFFFFFF, 1, ERR,  32'h0,        "t4_oor");
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'h02,  32'h0,        1, ERR,  32'h0,        "t4_misw");
        xfer(0, TR_NSEQ, 1'b1, 3'd1, 32'h11,  32'hFFFFFFFF, 1, ERR,  32'h0,        "t4_mish");
        xfer(1, TR_NSEQ, 1'b0, 3'd3, 32'h10,  32'h0,        1, ERR,  32'h0,        "t4_size");
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'h00,  32'h0,        0, OKAY, 32'h0,        "t4_rd0");
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'h10,  32'h0,        0, OKAY, 32'h1234ABEF, "t4_rd10");
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'hFC,  32'h0,        0, OKAY, 32'h0,        "t4_last");

        // IDLE / BUSY / unselected transfers do nothing
        xfer(0, TR_IDLE, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF, 0, OKAY, 32'h0, "t5_idle");
        xfer(0, TR_BUSY, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF, 0, OKAY, 32'h0, "t5_busy");
        xfer(3, TR_NSEQ, 1'b1, 3'd2, 32'h10, 32'hFFFFFFFF, 0, OKAY, 32'h0, "t5_nosel");
        drain();

        // NONSEQ write presented while another slave holds HREADY low
        sel        = 2'd0;
        htrans     = TR_NSEQ;
        hwrite     = 1'b1;
        hsize      = 3'd2;
        haddr      = 32'h10;
        hwdata     = 32'h12345678;
        force_nrdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        htrans = TR_IDLE;
        @(posedge clk);
        #1;
        force_nrdy = 1'b0;
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0, 0, OKAY, 32'h1234ABEF, "t5_rd");
        drain();

        // Reset during the second wait cycle of a WAIT_STATES=3 write
        sel    = 2'd2;
        htrans = TR_NSEQ;
        hwrite = 1'b1;
        hsize  = 3'd2;
        haddr  = 32'h20;
        n      = 0;
        @(negedge clk);
        while (!hready_bus && (n < 50)) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        htrans = TR_IDLE;
        hwdata = 32'h55AA55AA;
        @(negedge clk);
        check("t6_wait1_ready", 32'(rdy[2]), 32'h0);
        @(negedge clk);
        check("t6_wait2_ready", 32'(rdy[2]), 32'h0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 32'(rdy[2]),  32'h1);
        check("t6_rst_resp",  32'(resp[2]), 32'h0);
        check("t6_rst_rdata", rdata[2],     32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(2, TR_NSEQ, 1'b0, 3'd2, 32'h20, 32'h0, 3, OKAY, 32'h0, "t6_rd");
        xfer(0, TR_NSEQ, 1'b0, 3'd2, 32'h10, 32'h0, 0, OKAY, 32'h0, "t6_rd0");
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
